// File: rtl/sprite_scheduler.sv
// Sprite scheduler for the HDMI graphics path: double-buffered sprite table,
// per-pixel priority hit test, sprite-sheet BROM addressing and a fixed
// 4-cycle pipeline that keeps colour aligned with the delayed syncs.
module sprite_scheduler #(
  parameter int          NUM_SPRITES = 8,
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          NUM_FRAMES  = 4,
  parameter int          V_ACTIVE    = 720,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic                           clk_pixel,
  input  logic                           sys_rst,
  input  logic [9:0]                     hcount,
  input  logic [10:0]                    vcount,
  input  logic                           active_draw,
  input  logic                           hor_sync,
  input  logic                           vert_sync,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_index,
  input  logic                           wr_sprite_valid,
  input  logic [9:0]                     wr_x,
  input  logic [10:0]                    wr_y,
  input  logic [3:0]                     wr_frame,
  input  logic                           commit,
  output logic                           commit_done,
  output logic [9:0]                     brom_addr,
  input  logic [23:0]                    brom_data,
  output logic [7:0]                     red,
  output logic [7:0]                     green,
  output logic [7:0]                     blue,
  output logic                           active_draw_out,
  output logic                           hor_sync_out,
  output logic                           vert_sync_out
);

  localparam int                IDX_W    = $clog2(NUM_SPRITES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [10:0]       V_TRIG   = 11'(V_ACTIVE);
  localparam logic [4:0]        FRAMES_L = 5'(NUM_FRAMES);

  typedef struct packed {
    logic        valid;
    logic [9:0]  x;
    logic [10:0] y;
    logic [3:0]  frame;
  } entry_t;

  // Per-stage side information travelling alongside the BROM read.
  typedef struct packed {
    logic hit;
    logic act;
    logic hs;
    logic vs;
  } ctl_t;

  typedef enum logic {IDLE, COPY} state_t;

  entry_t           shadow_q [NUM_SPRITES];
  entry_t           shadow_d [NUM_SPRITES];
  entry_t           active_q [NUM_SPRITES];
  entry_t           active_d [NUM_SPRITES];
  state_t           state_q, state_d;
  logic [IDX_W-1:0] copy_idx_q, copy_idx_d;
  logic             pending_q, pending_d;
  logic             wr_ready_q, wr_ready_d;
  logic             commit_done_q, commit_done_d;

  logic [NUM_SPRITES-1:0] hit_vec;
  logic                   hit_any;
  logic [IDX_W-1:0]       sel;
  entry_t                 sel_e;
  logic [11:0]            h12, v12, x12, y12;
  logic [9:0]             brom_addr_q, brom_addr_d;

  ctl_t        ctl_q [3];
  ctl_t        ctl_d [3];
  logic [23:0] rgb_q, rgb_d;
  logic        act_out_q, act_out_d;
  logic        hs_out_q, hs_out_d;
  logic        vs_out_q, vs_out_d;

  // Table update and commit FSM: shadow writes in IDLE, one-entry-per-cycle copy in COPY.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    shadow_d      = shadow_q;
    active_d      = active_q;
    state_d       = state_q;
    copy_idx_d    = copy_idx_q;
    pending_d     = pending_q;
    commit_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready_q) begin
          shadow_d[wr_index] = '{valid: wr_sprite_valid, x: wr_x, y: wr_y, frame: wr_frame};
        end
        if (commit) pending_d = 1'b1;
        if (pending_q && vcount == V_TRIG && hcount == 10'd0) begin
          state_d    = COPY;
          copy_idx_d = '0;
          // The copy now in flight satisfies the request; any commit from here on targets the next frame.
          pending_d  = 1'b0;
        end
      end
      COPY: begin
        active_d[copy_idx_q] = shadow_q[copy_idx_q];
        if (commit) pending_d = 1'b1;
        if (copy_idx_q == LAST_IDX) begin
          state_d       = IDLE;
          commit_done_d = 1'b1;
        end else begin
          copy_idx_d = copy_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ready_d = (state_d == IDLE);
  end

  // Hit test against the active table; widened compares keep x+W / y+H from wrapping.
  always_comb begin
    hit_vec = '0;
    hit_any = 1'b0;
    sel     = '0;
    h12     = {2'b00, hcount};
    v12     = {1'b0, vcount};
    x12     = '0;
    y12     = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x12 = {2'b00, active_q[i].x};
      y12 = {1'b0, active_q[i].y};
      hit_vec[i] = active_q[i].valid && ({1'b0, active_q[i].frame} < FRAMES_L) &&
                   (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
                   (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
    end
    // Scan downwards so the lowest-index hit is the one left in sel.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        sel     = IDX_W'(i);
      end
    end
    sel_e       = active_q[sel];
    brom_addr_d = '0;
    if (hit_any) begin
      brom_addr_d = 10'(sel_e.frame) * 10'(SPRITE_W * SPRITE_H) +
                    10'(vcount - sel_e.y) * 10'(SPRITE_W) + (hcount - sel_e.x);
    end
  end

  // Delay line for hit/syncs and final colour select once brom_data is valid.
  always_comb begin
    ctl_d[0]  = '{hit: hit_any, act: active_draw, hs: hor_sync, vs: vert_sync};
    ctl_d[1]  = ctl_q[0];
    ctl_d[2]  = ctl_q[1];
    act_out_d = ctl_q[2].act;
    hs_out_d  = ctl_q[2].hs;
    vs_out_d  = ctl_q[2].vs;
    if (!ctl_q[2].act) begin
      rgb_d = 24'h000000;
    end else if (ctl_q[2].hit && brom_data != TRANSPARENT) begin
      rgb_d = brom_data;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // State register for the whole block.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      // NOTE: both tables are small flop arrays, so they are reset like any other state.
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int s = 0; s < 3; s++) ctl_q[s] <= '0;
      state_q       <= IDLE;
      copy_idx_q    <= '0;
      pending_q     <= 1'b0;
      wr_ready_q    <= 1'b0;
      commit_done_q <= 1'b0;
      brom_addr_q   <= '0;
      rgb_q         <= '0;
      act_out_q     <= 1'b0;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      ctl_q         <= ctl_d;
      state_q       <= state_d;
      copy_idx_q    <= copy_idx_d;
      pending_q     <= pending_d;
      wr_ready_q    <= wr_ready_d;
      commit_done_q <= commit_done_d;
      brom_addr_q   <= brom_addr_d;
      rgb_q         <= rgb_d;
      act_out_q     <= act_out_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
    end
  end

  assign wr_ready        = wr_ready_q;
  assign commit_done     = commit_done_q;
  assign brom_addr       = brom_addr_q;
  assign red             = rgb_q[23:16];
  assign green           = rgb_q[15:8];
  assign blue            = rgb_q[7:0];
  assign active_draw_out = act_out_q;
  assign hor_sync_out    = hs_out_q;
  assign vert_sync_out   = vs_out_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: a behavioural table model predicts
// brom_addr (t+1) and colour/syncs (t+4) for every driven pixel.
module tb_sprite_scheduler;

  localparam logic [23:0] TRANSP      = 24'hFF00FF;
  localparam logic [23:0] BG          = 24'h000000;
  localparam logic [9:0]  TRANSP_ADDR = 10'd347;

  logic        clk_pixel = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  hcount = '0;
  logic [10:0] vcount = '0;
  logic        active_draw = 1'b0, hor_sync = 1'b0, vert_sync = 1'b0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [2:0]  wr_index = '0;
  logic        wr_sprite_valid = 1'b0;
  logic [9:0]  wr_x = '0;
  logic [10:0] wr_y = '0;
  logic [3:0]  wr_frame = '0;
  logic        commit = 1'b0, commit_done;
  logic [9:0]  brom_addr;
  logic [23:0] brom_data = '0;
  logic [23:0] rom_s1 = '0;
  logic [7:0]  red, green, blue;
  logic        active_draw_out, hor_sync_out, vert_sync_out;

  sprite_scheduler dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst),
    .hcount(hcount), .vcount(vcount), .active_draw(active_draw),
    .hor_sync(hor_sync), .vert_sync(vert_sync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
    .wr_sprite_valid(wr_sprite_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame),
    .commit(commit), .commit_done(commit_done),
    .brom_addr(brom_addr), .brom_data(brom_data),
    .red(red), .green(green), .blue(blue),
    .active_draw_out(active_draw_out), .hor_sync_out(hor_sync_out),
    .vert_sync_out(vert_sync_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Sprite-sheet contents: top nibble A never matches the key except at TRANSP_ADDR.
  function automatic logic [23:0] rom_word(input logic [9:0] a);
    return (a == TRANSP_ADDR) ? TRANSP : {4'hA, 2'b00, a, 8'h5C};
  endfunction

  // Two-cycle-latency BROM.
  always @(posedge clk_pixel) begin
    rom_s1    <= rom_word(brom_addr);
    brom_data <= rom_s1;
  end

  typedef struct {bit v; int x; int y; int f;} ment_t;
  typedef struct {int due; logic [9:0] addr;} aexp_t;
  typedef struct {int due; logic [23:0] rgb; logic [2:0] ctl;} pexp_t;

  ment_t m_shadow [8];
  ment_t m_active [8];
  bit    m_pending, m_busy;
  aexp_t aq [$];
  pexp_t pq [$];
  int    cyc, n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '{0, 0, 0, 0};
      m_active[i] = '{0, 0, 0, 0};
    end
    m_pending = 0;
    m_busy    = 0;
  endtask

  // Reference hit test: first covering entry in index order, plain integer maths.
  task automatic model_pixel(input int h, input int v, output bit hit, output logic [9:0] addr);
    hit  = 0;
    addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && m_active[i].v && m_active[i].f < 4 &&
          h >= m_active[i].x && h < m_active[i].x + 16 &&
          v >= m_active[i].y && v < m_active[i].y + 16) begin
        hit  = 1;
        addr = 10'(m_active[i].f * 256 + (v - m_active[i].y) * 16 + (h - m_active[i].x));
      end
    end
  endtask

  // Advance one clock and compare every expectation that falls due now.
  task automatic tick();
    aexp_t ea;
    pexp_t ep;
    @(posedge clk_pixel);
    cyc++;
    #1;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ea = aq.pop_front();
      check("brom_addr", brom_addr, ea.addr);
    end
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      ep = pq.pop_front();
      check("rgb", {red, green, blue}, ep.rgb);
      check("syncs", {active_draw_out, hor_sync_out, vert_sync_out}, ep.ctl);
    end
  endtask

  // Predict outputs for the inputs currently driven, update the table model, then clock.
  task automatic cycle();
    bit          hit;
    logic [9:0]  addr;
    logic [23:0] word, rgb;
    model_pixel(int'(hcount), int'(vcount), hit, addr);
    word = rom_word(addr);
    rgb  = !active_draw ? 24'h000000 : ((hit && word != TRANSP) ? word : BG);
    aq.push_back('{cyc + 1, addr});
    pq.push_back('{cyc + 4, rgb, {active_draw, hor_sync, vert_sync}});
    if (wr_valid && !m_busy) m_shadow[wr_index] = '{wr_sprite_valid, int'(wr_x), int'(wr_y), int'(wr_frame)};
    if (commit) m_pending = 1;
    tick();
  endtask

  task automatic pix(input int h, input int v, input bit act);
    hcount      = 10'(h);
    vcount      = 11'(v);
    active_draw = act;
    hor_sync    = 1'($urandom_range(0, 1));
    vert_sync   = 1'($urandom_range(0, 1));
    cycle();
  endtask

  task automatic write_entry(input int idx, input bit v, input int x, input int y, input int f,
                             input bit with_commit);
    hcount = '0; vcount = '0; active_draw = 0;
    wr_index = 3'(idx); wr_sprite_valid = v;
    wr_x = 10'(x); wr_y = 11'(y); wr_frame = 4'(f);
    wr_valid = 1; commit = with_commit;
    check("wr_ready_idle", wr_ready, 1'b1);
    cycle();
    wr_valid = 0; commit = 0;
  endtask

  task automatic do_commit();
    commit = 1;
    cycle();
    commit = 0;
  endtask

  // Hit the copy trigger line; poke drives a write and a commit in the middle of the copy.
  task automatic vblank(input bit poke);
    bit expect_copy;
    expect_copy = m_pending;
    hcount = '0; vcount = 11'd720; active_draw = 0;
    m_pending = 0;
    cycle();
    if (expect_copy) m_busy = 1;
    for (int k = 1; k <= 10; k++) begin
      check("commit_done", commit_done, expect_copy && k == 9);
      check("wr_ready_copy", wr_ready, !(expect_copy && k <= 8));
      if (k == 9 && expect_copy) begin
        m_busy = 0;
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
      end
      hcount = 10'(k);
      if (poke && k == 3) begin
        wr_index = 3'd1; wr_sprite_valid = 1; wr_x = 10'd400; wr_y = 11'd400; wr_frame = 4'd0;
        wr_valid = 1; commit = 1;
      end
      if (k == 4) begin
        wr_valid = 0; commit = 0;
      end
      if (k < 10) cycle();
    end
  endtask

  task automatic do_reset();
    sys_rst = 1;
    active_draw = 1; hor_sync = 1; vert_sync = 1; wr_valid = 0; commit = 0;
    aq.delete();
    pq.delete();
    tick();
    tick();
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_commit_done", commit_done, 1'b0);
    check("rst_brom_addr", brom_addr, 10'd0);
    check("rst_rgb", {red, green, blue}, 24'h0);
    check("rst_syncs", {active_draw_out, hor_sync_out, vert_sync_out}, 3'b000);
    sys_rst = 0;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    model_clear();

    // 1: reset, then an empty table gives 0 outside and BG inside the active area
    do_reset();
    pix(10, 10, 0);
    check("wr_ready_after_rst", wr_ready, 1'b1);
    for (int i = 0; i < 8; i++) pix(i * 50, i * 40, i[0]);

    // 2: single sprite, frame 2, corner addresses
    write_entry(0, 1, 100, 50, 2, 0);
    do_commit();
    vblank(0);
    pix(100, 50, 1);
    pix(115, 65, 1);
    pix(99, 50, 1);
    pix(116, 65, 1);
    pix(100, 66, 1);

    // 3: overlapping entries 0 and 3, write+commit in one cycle, transparent texel
    write_entry(0, 1, 190, 195, 1, 0);
    write_entry(3, 1, 200, 200, 3, 1);
    vblank(0);
    pix(200, 200, 1);
    pix(201, 200, 1);
    pix(215, 215, 1);
    pix(201, 200, 0);

    // 4: right-edge sprite must not wrap; out-of-range frame never drawn
    write_entry(5, 1, 1020, 300, 0, 0);
    write_entry(6, 1, 500, 500, 5, 1);
    vblank(0);
    for (int h = 0; h < 4; h++) begin
      pix(h, 300, 1);
      pix(h, 301, 1);
    end
    pix(1020, 300, 1);
    pix(1023, 301, 1);
    pix(500, 500, 1);
    pix(507, 507, 1);

    // 5: write rejected during copy, commit during copy triggers a second copy
    do_commit();
    vblank(1);
    pix(400, 400, 1);
    vblank(0);
    pix(400, 400, 1);
    pix(200, 200, 1);

    // 6: reset in the middle of a copy
    write_entry(2, 1, 600, 100, 1, 1);
    hcount = '0; vcount = 11'd720; active_draw = 0;
    cycle();
    cycle();
    cycle();
    check("wr_ready_mid_copy", wr_ready, 1'b0);
    do_reset();
    vblank(0);
    pix(600, 100, 1);
    pix(200, 200, 1);
    pix(1020, 300, 1);

    hcount = '0; vcount = '0; active_draw = 0;
    repeat (6) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
